fifo_push_packer: RTL and testbench



---
 rtl/fifo_push_packer.sv | 89 ++++++++
 tb/tb_fifo_push_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_packer.sv
// Packs narrow input beats little-endian into one flagged word and drives a FIFO push port.
// The MSB of each word marks end-of-packet; a packet counter tracks flagged words emitted.
module fifo_push_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 8,
    parameter int RATIO      = DATA_WIDTH / IN_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_data_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_grant_o,
    output logic [DATA_WIDTH:0]   out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_grant_i,
    output logic [CNT_WIDTH-1:0]  pkt_count_o
);

    localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if (RATIO < 2 || RATIO * IN_WIDTH != DATA_WIDTH) begin : g_bad_ratio
            $error("fifo_push_packer: DATA_WIDTH must be an integer multiple (>=2) of IN_WIDTH");
        end
    endgenerate

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] acc_p0;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH:0]   word_p1;
    logic                  vld_p1;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  complete;

    // Grant depends only on the output register, never on in_valid_i.
    assign in_grant_o  = !vld_p1 || out_grant_i;
    assign in_xfer     = in_valid_i && in_grant_o;
    assign out_xfer    = vld_p1 && out_grant_i;
    assign complete    = in_last_i || (idx == LAST_IDX);

    assign out_data_o  = word_p1;
    assign out_valid_o = vld_p1;
    assign pkt_count_o = pkt_cnt;

    always_comb begin
        merged = acc_p0 | (DATA_WIDTH'(in_data_i) << (IN_WIDTH * int'(idx)));
    end

    // Stage p0: lane fill; higher lanes stay zero because the accumulator clears per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            acc_p0 <= '0;
        end else if (in_xfer) begin
            if (complete) begin
                idx    <= '0;
                acc_p0 <= '0;
            end else begin
                idx    <= idx + IDX_W'(1);
                acc_p0 <= merged;
            end
        end
    end

    // Stage p1: output word register, reloads in the same cycle it is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_p1 <= '0;
            vld_p1  <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (in_xfer && complete) begin
                word_p1 <= {in_last_i, merged};
                vld_p1  <= 1'b1;
            end else if (out_xfer) begin
                vld_p1  <= 1'b0;
            end
            if (out_xfer && word_p1[DATA_WIDTH]) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_packer.sv
// Scoreboard bench for fifo_push_packer, with a small depth-4 FIFO model on the push side.
module tb_fifo_push_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_grant;
    logic [32:0] out_data;
    logic        out_valid;
    logic        out_grant;
    logic [15:0] pkt_count;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];
    logic [31:0] m_acc;
    int          m_idx;

    logic grant_drv = 1'b1;
    logic fifo_mode = 1'b0;
    logic pop_en    = 1'b0;
    logic [32:0] fmem [4];
    int fwr, frd, fcnt;
    logic fifo_full;

    always #5 clk = ~clk;

    fifo_push_packer #(
        .DATA_WIDTH(32), .IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_grant_o(in_grant),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_grant_i(out_grant),
        .pkt_count_o(pkt_count)
    );

    assign fifo_full = (fcnt == 4);
    assign out_grant = fifo_mode ? !fifo_full : grant_drv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwr <= 0; frd <= 0; fcnt <= 0;
        end else begin
            logic push, pop;
            push = fifo_mode && out_valid && out_grant;
            pop  = pop_en && (fcnt > 0);
            if (push) begin
                fmem[fwr] <= out_data;
                fwr <= (fwr + 1) % 4;
            end
            if (pop) frd <= (frd + 1) % 4;
            fcnt <= fcnt + (push ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Scoreboard: expected words are pushed on accepted beats and checked on each output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
            m_acc = '0;
        end else begin
            if (out_valid && out_grant) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_word_unexpected: got %h, required no word", out_data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_word: got %h, required %h", out_data, e);
                    end
                end
            end
            if (in_valid && in_grant) begin
                m_acc[m_idx*8 +: 8] = in_data;
                if (in_last || m_idx == 3) begin
                    exp_q.push_back({in_last, m_acc});
                    m_idx = 0;
                    m_acc = '0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit done = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_grant) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: beat %h accepted=0, required 1", d);
        end
    endtask

    task automatic test_reset();
        grant_drv = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        if (out_data !== 33'h0) begin errors++; $display("FAIL rst_data: got %h, required 0", out_data); end
        if (pkt_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h, required 0", pkt_count); end
        if (in_grant !== 1'b1) begin errors++; $display("FAIL rst_grant: got %b, required 1", in_grant); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_grant !== 1'b1) begin errors++; $display("FAIL post_rst_grant: got %b, required 1", in_grant); end
        grant_drv = 1'b1;
    endtask

    task automatic test_full_word();
        do_reset();
        grant_drv = 1'b1;
        send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b, required 1", out_valid); end
        if (out_data !== 33'h1_44332211) begin errors++; $display("FAIL full_data: got %h, required 144332211", out_data); end
        if (pkt_count !== 16'd0) begin errors++; $display("FAIL full_count_early: got %0d, required 0", pkt_count); end
        @(posedge clk); #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_one_cycle: got %b, required 0", out_valid); end
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL full_count: got %0d, required 1", pkt_count); end
    endtask

    task automatic test_partial_word();
        send_beat(8'hAA, 0); send_beat(8'hBB, 0); send_beat(8'hCC, 1);
        checks++;
        if (out_data !== 33'h1_00CCBBAA) begin errors++; $display("FAIL partial_data: got %h, required 100CCBBAA", out_data); end
        send_beat(8'hDD, 1);
        checks++;
        if (out_data !== 33'h1_000000DD) begin errors++; $display("FAIL lane0_restart: got %h, required 1000000DD", out_data); end
        @(posedge clk); #1;
        checks++;
        if (pkt_count !== 16'd3) begin errors++; $display("FAIL partial_count: got %0d, required 3", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        grant_drv = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_beat(8'(i), 0);
            end
            begin
                bit seen = 0;
                bit found2 = 0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                checks++;
                if (!seen) begin errors++; $display("FAIL bp_first_word: valid=0, required 1"); end
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks += 3;
                    if (out_data !== 33'h0_04030201) begin errors++; $display("FAIL bp_hold_data: got %h, required 004030201", out_data); end
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid); end
                    if (in_grant !== 1'b0) begin errors++; $display("FAIL bp_hold_grant: got %b, required 0", in_grant); end
                end
                @(posedge clk); #1 grant_drv = 1'b1;
                for (int c = 0; c < 20 && !found2; c++) begin
                    @(negedge clk);
                    if (out_valid && out_data === 33'h0_08070605) found2 = 1;
                end
                checks++;
                if (!found2) begin errors++; $display("FAIL bp_second_word: seen=0, required 008070605"); end
            end
        join
        repeat (2) @(posedge clk); #1;
        checks++;
        if (pkt_count !== 16'd0) begin errors++; $display("FAIL bp_count: got %0d, required 0", pkt_count); end
    endtask

    task automatic test_single_wrap();
        do_reset();
        grant_drv = 1'b1;
        send_beat(8'h5A, 1);
        checks += 2;
        if (out_data !== 33'h1_0000005A) begin errors++; $display("FAIL single_data: got %h, required 10000005A", out_data); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", pkt_count); end
        in_data = 8'h5A; in_last = 1'b1; in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks += 2;
        if (pkt_count !== 16'd0) begin errors++; $display("FAIL count_wrap: got %0d, required 0", pkt_count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b, required 0", out_valid); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        grant_drv = 1'b1;
        send_beat(8'h77, 0); send_beat(8'h88, 0);
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 1);
        checks++;
        if (out_data !== 33'h1_04030201) begin errors++; $display("FAIL mid_rst_data: got %h, required 104030201", out_data); end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_rst_pending: got %0d words, required 0", exp_q.size()); end
    endtask

    task automatic test_fifo_stream();
        logic [32:0] wexp [5];
        int npop = 0;
        do_reset();
        fifo_mode = 1'b1;
        pop_en = 1'b0;
        for (int w = 0; w < 5; w++) begin
            wexp[w] = {1'b1, 8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
            for (int b = 0; b < 4; b++) send_beat(8'(4*w+b+1), b == 3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (fcnt !== 4) begin errors++; $display("FAIL fifo_fill: got %0d, required 4", fcnt); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fifo_held_valid: got %b, required 1", out_valid); end
        if (in_grant !== 1'b0) begin errors++; $display("FAIL fifo_held_grant: got %b, required 0", in_grant); end
        if (out_data !== wexp[4]) begin errors++; $display("FAIL fifo_held_data: got %h, required %h", out_data, wexp[4]); end
        @(posedge clk); #1 pop_en = 1'b1;
        for (int c = 0; c < 40 && npop < 5; c++) begin
            @(negedge clk);
            if (fcnt > 0) begin
                checks++;
                if (fmem[frd] !== wexp[npop]) begin
                    errors++;
                    $display("FAIL fifo_pop%0d: got %h, required %h", npop, fmem[frd], wexp[npop]);
                end
                npop++;
            end
        end
        @(posedge clk); #1;
        checks += 3;
        if (npop !== 5) begin errors++; $display("FAIL fifo_pop_count: got %0d, required 5", npop); end
        if (fcnt !== 0) begin errors++; $display("FAIL fifo_drained: got %0d, required 0", fcnt); end
        if (pkt_count !== 16'd5) begin errors++; $display("FAIL fifo_pkt_count: got %0d, required 5", pkt_count); end
        pop_en = 1'b0;
        fifo_mode = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; rst_n = 1'b0;
        test_reset();
        test_full_word();
        test_partial_word();
        test_backpressure();
        test_reset_mid_word();
        test_fifo_stream();
        test_single_wrap();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL final_pending: got %0d words, required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
